// File: rtl/vertex_xform_mac.sv
// Vertex transform: R = T x V with one time-shared signed MAC.
// Result is published atomically on commit with its state tag.
module vertex_xform_mac #(
  parameter int W    = 21,
  parameter int FRAC = 10
) (
  input  logic            CLK,
  input  logic            rst,
  input  logic            start,
  input  logic [16*W-1:0] xform_in,
  input  logic [16*W-1:0] vtx_in,
  input  logic [3:0]      state_in,
  output logic            busy,
  output logic            done,
  output logic            sat,
  output logic [16*W-1:0] mtrxOut,
  output logic [3:0]      matrixState
);

  localparam int AW = 2*W + 2;

  localparam logic signed [AW-1:0] MAXV =
    {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV =
    {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    COMMIT
  } state_t;

  state_t state;

  logic [5:0]            cnt;
  logic [3:0]            tag;
  logic                  job_sat;
  logic signed [AW-1:0]  acc;
  logic signed [AW-1:0]  sum;
  logic signed [AW-1:0]  shifted;
  logic signed [2*W-1:0] prod;
  logic signed [W-1:0]   elem;
  logic                  clamp;

  logic signed [W-1:0] x_el [16];
  logic signed [W-1:0] v_el [16];
  logic signed [W-1:0] t_m  [16];
  logic signed [W-1:0] v_m  [16];
  logic signed [W-1:0] sh_m [16];
  logic [16*W-1:0]     sh_bus;

  // Element k of a bus lives at the k-th W-bit slot from the MSB end.
  for (genvar k = 0; k < 16; k++) begin : g_pack
    assign x_el[k] = xform_in[16*W-1-k*W -: W];
    assign v_el[k] = vtx_in[16*W-1-k*W -: W];
    assign sh_bus[16*W-1-k*W -: W] = sh_m[k];
  end

  // MAC datapath: term t=cnt[1:0], row i=cnt[3:2], column j=cnt[5:4].
  always_comb begin
    prod = t_m[{cnt[1:0], cnt[3:2]}]
         * v_m[{cnt[5:4], cnt[1:0]}];
    sum = acc + {{2{prod[2*W-1]}}, prod};
    shifted = sum >>> FRAC;
    elem = shifted[W-1:0];
    clamp = 1'b0;
    if (shifted > MAXV) begin
      elem = MAXV[W-1:0];
      clamp = 1'b1;
    end else if (shifted < MINV) begin
      elem = MINV[W-1:0];
      clamp = 1'b1;
    end
  end

  // Job sequencer: latch operands, run 64 MACs, then commit.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      tag         <= '0;
      job_sat     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      sat         <= 1'b0;
      mtrxOut     <= '0;
      matrixState <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            t_m     <= x_el;
            v_m     <= v_el;
            tag     <= state_in;
            acc     <= '0;
            cnt     <= '0;
            job_sat <= 1'b0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          cnt <= cnt + 6'd1;
          if (cnt[1:0] == 2'd3) begin
            sh_m[cnt[5:2]] <= elem;
            acc <= '0;
            if (clamp) job_sat <= 1'b1;
          end else begin
            acc <= sum;
          end
          if (cnt == 6'd63) state <= COMMIT;
        end
        COMMIT: begin
          mtrxOut     <= sh_bus;
          matrixState <= tag;
          sat         <= job_sat;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vertex_xform_mac.md
Name: vertex_xform_mac

Overview:
- Upstream stage of the renderer. Computes R = T x V once per request using one time-shared signed multiply-accumulate.
- T is a 4x4 transform matrix (rotation/translation/projection); V holds the four tetrahedron vertices as homogeneous columns.
- Output bus uses the packing the renderer's matrix input expects. It updates atomically on commit, so the renderer never sees a half-written matrix.
- Intended to be started once per frame, e.g. on vertical blank.

Parameters:
- W, 21, element width: signed fixed point, sign + 10 integer + FRAC bits.
- FRAC, 10, fractional bits; product rescale shift.

Ports:
- CLK  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- xform_in  input  16*W  matrix T, packed as below.
- vtx_in  input  16*W  matrix V, packed as below.
- state_in  input  4  matrix-state tag, forwarded with the result.
- busy  output  1  high while a job is in flight.
- done  output  1  one-cycle pulse coincident with the result update.
- sat  output  1  at least one element of the last committed job saturated.
- mtrxOut  output  16*W  result R, packed as below.
- matrixState  output  4  state_in latched at job start, published at commit.

Behaviour:
- Clock and reset: one clock, CLK. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, sat=0, mtrxOut=0, matrixState=0, FSM=IDLE, counter=0.
- Reset mid-job: aborts the job. No commit, no done; outputs take reset values.
- Packing (all 16*W buses): column-major, element d11 in the MSBs. Order is d11,d21,d31,d41,d12,...,d44.
  - Element dij has k=(j-1)*4+(i-1) and occupies bits [16*W-1-k*W -: W].
- FSM states: IDLE, CALC, COMMIT.
  - IDLE: on the edge where start=1 (call it edge 0), latch xform_in, vtx_in and state_in into operand registers. Clear the accumulator, cnt=0, go to CALC, busy=1.
  - Input buses may change freely after edge 0; the job uses only latched copies.
  - CALC: one MAC per edge, edges 1..64, cnt 0..63.
    - Term t=cnt[1:0]. Output element index e=cnt[5:2], with i=e%4+1 and j=e/4+1.
    - acc += T[i][t+1] * V[t+1][j], using the full 2W-bit product and an accumulator of at least 2W+2 bits, with no intermediate rounding.
    - When t=3: shift the final sum arithmetically right by FRAC (floor). Saturate to [-2^(W-1), 2^(W-1)-1] and write it into the shadow element e.
    - Set the job-local sat flag if clamping occurred. Clear acc for the next element.
    - After cnt=63, go to COMMIT.
  - COMMIT (edge 65): mtrxOut <= shadow, matrixState <= latched tag, sat <= job-local flag, done=1, busy=0, go to IDLE.
- Latency: start sampled at edge 0 gives done high for the cycle following edge 65, deasserted after edge 66. mtrxOut changes only at commit edges.
- start while busy (CALC/COMMIT): ignored, not queued.
- Back-to-back: start high in the cycle done is high is sampled in IDLE and accepted. The next done follows 65 edges later.
- done is never asserted without a full 64-term job.
- Shadow register contents are not visible at the outputs before commit.
- Multiplier: single W x W signed multiplier, combinational or 1-stage registered. If registered, the implementation must add the pipeline cycle without changing the 65-edge done latency; otherwise use the combinational multiplier.

Test Plan:
- Identity: T=I (diag 0x000400), V columns (1,2,3,1),(−1,0,2,1),(0.5,−0.5,0,1),(4,4,4,1); start=1, state_in=4'h3 -> done exactly at edge 65, mtrxOut==vtx_in bit-exact, matrixState=4'h3, sat=0, busy high during edges 1..64.
- Scale+translate: T=diag(2,2,2,1) with T[1][4]=1.0 and V as above -> column 1 = (3,4,6,1), i.e. d11=0x000C00, d21=0x001000, d31=0x001800, d41=0x000400.
- Saturation and floor: T=diag(1023.0) with V[1][1]=2.0 -> d11=0x0FFFFF, sat=1. T=0.5*I with V[1][1]=-1 LSB (0x1FFFFF) -> d11=0x1FFFFF (floor, not 0), sat=0.
- Ignored start and input isolation: start again at edges 10 and 40 and change xform_in at edge 5 -> exactly one done at edge 65, result from the operands latched at edge 0. A start in the done cycle is accepted, with the next done at edge 131.
- Reset mid-job: start at edge 0 after a prior committed result, rst=1 at edge 30 -> mtrxOut=0, matrixState=0, busy=0, no done pulse. A new start afterwards completes normally in 65 edges.
